split_bus_arbiter: RTL and testbench
====================================

// Module: split_bus_arbiter
// PURPOSE
//  Bus arbiter directly upstream of split_s_port. It grants the shared serial bus to one of NUM_MASTERS masters.
//  When the owning slave answers with split_ack, the arbiter parks that master and frees the bus for other masters.
//  When the slave raises split_req, the arbiter re-grants the bus to the parked master and pulses split_grant.
//  split_grant drives split_s/split_s_port arbiter_grant.
// PARAMETERS
//  NUM_MASTERS          2   number of requesting masters (2..4); index 0 has highest priority
//  SPLIT_GRANT_LATENCY  2   cycles from split_req being accepted to the split_grant pulse (1..7)
// PORTS
//  clk          in   1              clock, all logic on posedge
//  rst          in   1              synchronous reset, active-high
//  m_req        in   NUM_MASTERS    per-master bus request; held high for the whole transaction
//  m_grant      out  NUM_MASTERS    one-hot grant, registered
//  bus_owner    out  $clog2(NM)     index of the current owner; valid while bus_busy
//  bus_busy     out  1              the bus is granted (normal grant or split resume)
//  split_ack    in   1              slave split acknowledge (bus_split_ack), 1-cycle pulse
//  split_req    in   1              slave ready to resume (arbiter_split_req), level
//  split_grant  out  1              1-cycle pulse to the split slave when the parked master resumes
//  split_pending out 1              a master is parked awaiting split completion
//  split_err    out  1              sticky: split_ack arrived while a split was already pending
// BEHAVIOUR
//  Reset: rst=1 at a posedge gives the following at that edge, including mid-transaction.
//   - Outputs: m_grant=0, bus_owner=0, bus_busy=0, split_grant=0, split_pending=0, split_err=0.
//   - Internal: state=IDLE, latency counter=0, parked-master id=0.
//  FSM states: IDLE, GRANT, RESUME_WAIT.
//   - IDLE, split resume: if split_pending && split_req, load counter=SPLIT_GRANT_LATENCY and go to RESUME_WAIT.
//     Split resume has priority over new requests.
//   - IDLE, new grant: else if any eligible m_req, pick the lowest eligible index, set m_grant/bus_owner/bus_busy
//     at the next edge, and go to GRANT. Latency from request to grant is 1 cycle.
//   - Eligibility: m_req masked by the parked master while split_pending; its m_req stays high and is ignored.
//   - GRANT, split: if split_ack, record the parked id=bus_owner, set split_pending=1, clear the grant next edge,
//     and go to IDLE.
//   - GRANT, release: else if !m_req[bus_owner], clear the grant next edge and go to IDLE.
//   - GRANT, same-cycle split_ack and req drop: split_ack wins; the master is parked.
//   - GRANT, split_req seen: split_req during GRANT is not serviced until the owner releases; it is level, so no latch.
//   - RESUME_WAIT: counter decrements each cycle. On the cycle counter==1 the edge produces:
//     split_grant=1 for 1 cycle, m_grant[parked]=1, bus_owner=parked, bus_busy=1, split_pending=0; then go to GRANT.
//   - RESUME_WAIT vs new requests: m_req changes are ignored; there is no preemption.
//  Turnaround: after any release or split there is at least one IDLE cycle with m_grant=0 before the next grant.
//  Split overflow: split_ack while split_pending sets split_err (cleared only by rst). The second split_ack is
//   otherwise ignored: the owner keeps its grant and the original parked id is kept.
//  Stray inputs: split_ack outside GRANT is ignored. split_req without split_pending is ignored.
//  m_grant is always one-hot or zero. bus_busy == |m_grant. bus_owner holds its last value while idle.
//  Counter width: $clog2(SPLIT_GRANT_LATENCY+1); no wrap (loaded only from IDLE).
// STRUCTURE
//  bus_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, GRANT, RESUME_WAIT} arb_state_t
//   - localparams for default NUM_MASTERS and SPLIT_GRANT_LATENCY
//   - function onehot(idx)
//  Sub-module arb_prio_enc: combinational fixed-priority encoder.
//   - Inputs: req vector and mask.
//   - Outputs: found and idx.
//  Top level: FSM, counter, parked-id register, and output registers. No other hierarchy.
// TESTING
//  Single grant:
//   - m_req=2'b01 at t0 -> m_grant=01, bus_owner=0 at t0+1.
//   - Drop req -> m_grant=00 next cycle.
//  Priority:
//   - m_req=2'b11 from IDLE -> m_grant=01.
//   - Master 0 releases -> one idle cycle, then m_grant=10.
//  Split path, SPLIT_GRANT_LATENCY=2:
//   - M0 granted, split_ack pulse -> m_grant=00, split_pending=1.
//   - M1 (req=1) granted on the following cycle; it completes and releases.
//   - split_req=1 -> split_grant pulse exactly 2 cycles after the IDLE accept, with m_grant=01 on the same cycle.
//   - split_pending=0 after that.
//  Same-cycle events:
//   - split_ack with m_req[owner] dropping -> master parked, split_pending=1.
//   - split_req=1 while M1 holds the bus -> no split_grant until M1 releases.
//  Overflow:
//   - Second split_ack (from M1) while M0 is parked -> split_err=1 sticky.
//   - M1 grant is unaffected; parked id stays 0.
//  Reset mid-op: rst=1 during RESUME_WAIT -> all outputs 0 next edge, no split_grant pulse afterwards.

Source files
------------

// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and helpers for the split-capable bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT       = 2'd1,
        RESUME_WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_MASTERS         = 2;
    localparam int DEF_SPLIT_GRANT_LATENCY = 2;
    localparam int MAX_MASTERS             = 4;

    // One-hot vector over the largest supported master count.
    function automatic logic [MAX_MASTERS-1:0] onehot(input int idx);
        logic [MAX_MASTERS-1:0] v;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            v[i] = (i == idx);
        end
        return v;
    endfunction

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Bus-side handshake of the split arbiter: master requests, grants and split signalling.
interface split_bus_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS
);
    localparam int IW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_grant;
    logic [IW-1:0]          bus_owner;
    logic                   bus_busy;
    logic                   split_ack;
    logic                   split_req;
    logic                   split_grant;
    logic                   split_pending;
    logic                   split_err;

    // master: the arbiter, which owns the grant side of the bus
    modport master (
        input  m_req, split_ack, split_req,
        output m_grant, bus_owner, bus_busy, split_grant, split_pending, split_err
    );

    modport slave (
        output m_req, split_ack, split_req,
        input  m_grant, bus_owner, bus_busy, split_grant, split_pending, split_err
    );

endinterface

// File: rtl/split_bus_arbiter_prio_enc.sv
// Fixed-priority encoder: lowest unmasked requesting index wins.
module arb_prio_enc #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] elig;

    always_comb begin
        elig  = req & ~mask;
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// Split-capable bus arbiter: grants the shared bus, parks split masters and resumes
// them with a split_grant pulse a fixed number of cycles after the slave asks.
module split_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS         = DEF_NUM_MASTERS,
    parameter int SPLIT_GRANT_LATENCY = DEF_SPLIT_GRANT_LATENCY
) (
    input logic       clk,
    input logic       rst,
    split_bus_if.master bus
);

    localparam int NM = NUM_MASTERS;
    localparam int IW = $clog2(NM);
    localparam int CW = $clog2(SPLIT_GRANT_LATENCY + 1);

    arb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          parked_q, parked_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [MAX_MASTERS-1:0] grant_q, grant_d;
    logic                   split_grant_q, split_grant_d;
    logic                   pending_q, pending_d;
    logic                   err_q, err_d;

    logic [NM-1:0]          mask;
    logic                   found;
    logic [IW-1:0]          idx;

    // The parked master keeps its request high; hide it until it is resumed.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            mask[i] = pending_q && (parked_q == IW'(i));
        end
    end

    arb_prio_enc #(
        .N  (NM),
        .IW (IW)
    ) u_prio_enc (
        .req   (bus.m_req),
        .mask  (mask),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            parked_q      <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            split_grant_q <= 1'b0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            parked_q      <= parked_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            split_grant_q <= split_grant_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        parked_d      = parked_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        split_grant_d = 1'b0;
        pending_d     = pending_q;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (pending_q && bus.split_req) begin
                    cnt_d   = CW'(SPLIT_GRANT_LATENCY);
                    state_d = RESUME_WAIT;
                end else if (found) begin
                    grant_d = onehot(int'(idx));
                    owner_d = idx;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (bus.split_ack && pending_q) begin
                    err_d = 1'b1;
                end
                if (bus.split_ack && !pending_q) begin
                    parked_d  = owner_q;
                    pending_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else if (!bus.m_req[owner_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end

            RESUME_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d         = '0;
                    split_grant_d = 1'b1;
                    grant_d       = onehot(int'(parked_q));
                    owner_d       = parked_q;
                    pending_d     = 1'b0;
                    state_d       = GRANT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.m_grant       = grant_q[NM-1:0];
    assign bus.bus_owner     = owner_q;
    assign bus.bus_busy      = |grant_q;
    assign bus.split_grant   = split_grant_q;
    assign bus.split_pending = pending_q;
    assign bus.split_err     = err_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter with two masters and a resume latency of 2.
module tb_split_bus_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    split_bus_if #(.NUM_MASTERS(2)) bif ();

    split_bus_arbiter #(
        .NUM_MASTERS         (2),
        .SPLIT_GRANT_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] g, input logic sg, input logic pend);
        chk({tag, "_grant"}, 32'(bif.m_grant), 32'(g));
        chk({tag, "_busy"}, 32'(bif.bus_busy), 32'(|g));
        chk({tag, "_sgrant"}, 32'(bif.split_grant), 32'(sg));
        chk({tag, "_pend"}, 32'(bif.split_pending), 32'(pend));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bif.m_req     = 2'b00;
        bif.split_ack = 1'b0;
        bif.split_req = 1'b0;
        step();
        step();
        chk_bus("rst", 2'b00, 1'b0, 1'b0);
        chk("rst_owner", 32'(bif.bus_owner), 32'd0);
        chk("rst_err", 32'(bif.split_err), 32'd0);
        rst = 1'b0;
        step();

        // single grant
        bif.m_req = 2'b01; step();
        chk_bus("single", 2'b01, 1'b0, 1'b0);
        chk("single_owner", 32'(bif.bus_owner), 32'd0);
        bif.m_req = 2'b00; step();
        chk_bus("single_rel", 2'b00, 1'b0, 1'b0);

        // priority and turnaround
        bif.m_req = 2'b11; step();
        chk_bus("prio", 2'b01, 1'b0, 1'b0);
        bif.m_req = 2'b10; step();
        chk_bus("prio_turn", 2'b00, 1'b0, 1'b0);
        step();
        chk_bus("prio_m1", 2'b10, 1'b0, 1'b0);
        chk("prio_owner", 32'(bif.bus_owner), 32'd1);
        bif.m_req = 2'b00; step();
        chk_bus("prio_rel", 2'b00, 1'b0, 1'b0);
        chk("owner_hold", 32'(bif.bus_owner), 32'd1);

        // split path
        bif.m_req = 2'b01; step();
        chk_bus("sp_g0", 2'b01, 1'b0, 1'b0);
        bif.split_ack = 1'b1; bif.m_req = 2'b11; step();
        bif.split_ack = 1'b0;
        chk_bus("sp_park", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("sp_m1", 2'b10, 1'b0, 1'b1);
        chk("sp_m1_owner", 32'(bif.bus_owner), 32'd1);
        bif.m_req = 2'b01; step();
        chk_bus("sp_m1_rel", 2'b00, 1'b0, 1'b1);
        bif.split_req = 1'b1; step();
        bif.split_req = 1'b0;
        chk_bus("sp_accept", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("sp_wait", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("sp_resume", 2'b01, 1'b1, 1'b0);
        chk("sp_resume_owner", 32'(bif.bus_owner), 32'd0);
        step();
        chk_bus("sp_after", 2'b01, 1'b0, 1'b0);
        bif.m_req = 2'b00; step();
        chk_bus("sp_rel", 2'b00, 1'b0, 1'b0);

        // same-cycle split_ack and request drop, then split_req while M1 owns the bus
        bif.m_req = 2'b01; step();
        chk_bus("sc_g0", 2'b01, 1'b0, 1'b0);
        bif.split_ack = 1'b1; bif.m_req = 2'b00; step();
        bif.split_ack = 1'b0;
        chk_bus("sc_park", 2'b00, 1'b0, 1'b1);
        bif.m_req = 2'b10; step();
        chk_bus("sc_m1", 2'b10, 1'b0, 1'b1);
        bif.split_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_bus("sc_hold", 2'b10, 1'b0, 1'b1);
        end
        bif.m_req = 2'b00; step();
        chk_bus("sc_m1_rel", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("sc_accept", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("sc_wait", 2'b00, 1'b0, 1'b1);
        step();
        bif.split_req = 1'b0;
        chk_bus("sc_resume", 2'b01, 1'b1, 1'b0);
        step();
        chk_bus("sc_rel", 2'b00, 1'b0, 1'b0);

        // split overflow
        bif.m_req = 2'b01; step();
        bif.split_ack = 1'b1; bif.m_req = 2'b11; step();
        bif.split_ack = 1'b0;
        chk_bus("ov_park", 2'b00, 1'b0, 1'b1);
        step();
        chk_bus("ov_m1", 2'b10, 1'b0, 1'b1);
        bif.split_ack = 1'b1; step();
        bif.split_ack = 1'b0;
        chk_bus("ov_second", 2'b10, 1'b0, 1'b1);
        chk("ov_err", 32'(bif.split_err), 32'd1);
        step();
        chk("ov_err_sticky", 32'(bif.split_err), 32'd1);
        chk("ov_m1_owner", 32'(bif.bus_owner), 32'd1);
        bif.m_req = 2'b01; step();
        chk_bus("ov_m1_rel", 2'b00, 1'b0, 1'b1);
        bif.split_req = 1'b1; step();
        bif.split_req = 1'b0;
        step();
        step();
        chk_bus("ov_resume", 2'b01, 1'b1, 1'b0);
        chk("ov_parked_id", 32'(bif.bus_owner), 32'd0);
        chk("ov_err_keep", 32'(bif.split_err), 32'd1);

        // reset during RESUME_WAIT
        bif.m_req = 2'b00; step();
        bif.m_req = 2'b01; step();
        bif.split_ack = 1'b1; bif.m_req = 2'b00; step();
        bif.split_ack = 1'b0;
        bif.split_req = 1'b1; step();
        chk_bus("rm_accept", 2'b00, 1'b0, 1'b1);
        rst = 1'b1; step();
        rst = 1'b0;
        chk_bus("rm_rst", 2'b00, 1'b0, 1'b0);
        chk("rm_err", 32'(bif.split_err), 32'd0);
        chk("rm_owner", 32'(bif.bus_owner), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bus("rm_after", 2'b00, 1'b0, 1'b0);
        end
        bif.split_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
